// File: rtl/jk_reg_pkg.sv
// ---------------------------------------------------------------------------
// jk_reg_pkg
//   Shared definitions for the JK-cell register/counter block.
//   - mode_e : operating mode encoding seen on the 2-bit mode port.
//   - jk_e   : the four J/K input combinations of a single cell, named by the
//              action they cause on the next clock edge.
// ---------------------------------------------------------------------------
package jk_reg_pkg;

    typedef enum logic [1:0] {
        MODE_JK  = 2'b00,   // per-bit J/K taken straight from the j/k ports
        MODE_UP  = 2'b01,   // modulo up counter
        MODE_DN  = 2'b10,   // modulo down counter
        MODE_SHL = 2'b11    // shift left, serial input into bit 0
    } mode_e;

    typedef enum logic [1:0] {
        JK_HOLD   = 2'b00,
        JK_CLEAR  = 2'b01,
        JK_SET    = 2'b10,
        JK_TOGGLE = 2'b11
    } jk_e;

endpackage : jk_reg_pkg

// File: rtl/jk_cell.sv
// ---------------------------------------------------------------------------
// jk_cell
//   One-bit JK flip-flop with synchronous active-low clear and preset and an
//   operation enable. Priority on each rising edge:
//     clr_n low > pre_n low > en low (hold) > J/K action.
//   Asserting clr_n and pre_n together resolves to 0, so the cell never has
//   an undefined state.
//
// Ports
//   clk    in   rising-edge clock
//   clr_n  in   synchronous active-low clear (q <= 0)
//   pre_n  in   synchronous active-low preset (q <= 1)
//   en     in   1 = apply J/K, 0 = hold
//   j, k   in   JK inputs: 00 hold, 01 clear, 10 set, 11 toggle
//   q      out  cell state
// ---------------------------------------------------------------------------
module jk_cell
    import jk_reg_pkg::*;
(
    input  logic clk,
    input  logic clr_n,
    input  logic pre_n,
    input  logic en,
    input  logic j,
    input  logic k,
    output logic q
);

    jk_e action;

    assign action = jk_e'({j, k});

    // NOTE: state registers use non-blocking (<=) assignments so every cell
    // samples the pre-edge value of its neighbours, which the counter decoder
    // relies on; blocking assignments here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            q <= 1'b0;
        end else if (!pre_n) begin
            q <= 1'b1;
        end else if (en) begin
            case (action)
                JK_HOLD:   q <= q;
                JK_CLEAR:  q <= 1'b0;
                JK_SET:    q <= 1'b1;
                JK_TOGGLE: q <= ~q;
                default:   q <= q;
            endcase
        end
    end

endmodule : jk_cell

// File: rtl/jk_counter_reg.sv
// ---------------------------------------------------------------------------
// jk_counter_reg
//   WIDTH-bit register built from jk_cell instances. A combinational decoder
//   turns the selected mode into per-bit J/K pairs:
//     MODE_JK  : j/k ports passed through unchanged
//     MODE_UP  : bit i toggles when all lower bits are one; when q has reached
//                or passed MODULUS-1 every bit is forced clear (wrap to 0)
//     MODE_DN  : bit i toggles when all lower bits are zero; when q is 0 or
//                above MODULUS-1 the bits are forced set/clear to MODULUS-1
//     MODE_SHL : each bit is forced to its shifted-in value (set/clear pair)
//   clear and preset are synchronous, active-low, and outrank en and mode.
//
// Parameters
//   WIDTH         register width, 1..32
//   MODULUS       count modulus for up/down modes, 2..2**WIDTH
//   PRESET_VALUE  value loaded by preset; clamped to MODULUS-1 if larger
//
// Ports
//   clk     in   rising-edge clock
//   clear   in   synchronous active-low clear, q <= 0 (beats preset)
//   preset  in   synchronous active-low preset, q <= PRESET_VALUE
//   en      in   1 = operate per mode, 0 = hold
//   mode    in   00 JK, 01 count up, 10 count down, 11 shift left
//   j, k    in   per-bit J/K, used in mode 00
//   sin     in   serial input into bit 0 in mode 11
//   q       out  register state
//   q_not   out  ~q
//   tc      out  terminal count for cascading into the next stage's en
// ---------------------------------------------------------------------------
module jk_counter_reg
    import jk_reg_pkg::*;
#(
    parameter int              WIDTH        = 8,
    parameter longint unsigned MODULUS      = 64'd1 << WIDTH,
    parameter longint unsigned PRESET_VALUE = (64'd1 << WIDTH) - 64'd1
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             preset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_not,
    output logic             tc
);

    // Largest in-range count value; MODULUS <= 2**WIDTH so it always fits.
    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 64'd1);

    // Preset value clamped into the counting range.
    localparam longint unsigned PRESET_CLAMPED =
        (PRESET_VALUE > MODULUS - 64'd1) ? MODULUS - 64'd1 : PRESET_VALUE;
    localparam logic [WIDTH-1:0] PRESET_Q = WIDTH'(PRESET_CLAMPED);

    mode_e            mode_sel;
    logic [WIDTH-1:0] up_toggle;   // bit i toggles on increment
    logic [WIDTH-1:0] dn_toggle;   // bit i toggles on decrement
    logic [WIDTH-1:0] shl_value;   // q shifted left with sin in bit 0
    logic             at_top;      // q >= MODULUS-1 (includes out-of-range)
    logic             above_top;   // q >  MODULUS-1 (out-of-range only)
    logic             at_zero;
    logic [WIDTH-1:0] next_j;
    logic [WIDTH-1:0] next_k;
    logic [WIDTH-1:0] cell_clr_n;
    logic [WIDTH-1:0] cell_pre_n;

    assign mode_sel  = mode_e'(mode);
    assign at_top    = (q >= MAX_Q);
    assign above_top = (q > MAX_Q);
    assign at_zero   = (q == '0);

    // Ripple toggle conditions: an increment flips bit i exactly when all
    // lower bits are one; a decrement flips it when all lower bits are zero.
    always_comb begin
        logic ones_below;
        logic zeros_below;
        ones_below  = 1'b1;
        zeros_below = 1'b1;
        up_toggle   = '0;
        dn_toggle   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            up_toggle[i] = ones_below;
            dn_toggle[i] = zeros_below;
            ones_below   = ones_below  &  q[i];
            zeros_below  = zeros_below & ~q[i];
        end
    end

    // A one-bit register has nothing to shift out; it just loads sin.
    generate
        if (WIDTH == 1) begin : g_shl_narrow
            assign shl_value = sin;
        end else begin : g_shl_wide
            assign shl_value = {q[WIDTH-2:0], sin};
        end
    endgenerate

    // Next-J/K decoder. Loads of a known value (wrap, out-of-range recovery,
    // shift) use J=value, K=~value so every bit is forced set or clear.
    // NOTE: both outputs get a default before the case so no path through
    // this block leaves them unassigned, which would otherwise infer latches.
    always_comb begin
        next_j = '0;
        next_k = '0;
        case (mode_sel)
            MODE_JK: begin
                next_j = j;
                next_k = k;
            end
            MODE_UP: begin
                if (at_top) begin
                    next_j = '0;
                    next_k = '1;
                end else begin
                    next_j = up_toggle;
                    next_k = up_toggle;
                end
            end
            MODE_DN: begin
                if (at_zero || above_top) begin
                    next_j = MAX_Q;
                    next_k = ~MAX_Q;
                end else begin
                    next_j = dn_toggle;
                    next_k = dn_toggle;
                end
            end
            MODE_SHL: begin
                next_j = shl_value;
                next_k = ~shl_value;
            end
            default: begin
                next_j = '0;
                next_k = '0;
            end
        endcase
    end

    // Preset is realised per bit: bits that are 1 in PRESET_Q use the cell's
    // preset, bits that are 0 use the cell's clear. The block-level clear is
    // folded into every cell's clear so it still wins over preset.
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_cell
            if (PRESET_Q[i]) begin : g_pre_one
                assign cell_clr_n[i] = clear;
                assign cell_pre_n[i] = preset;
            end else begin : g_pre_zero
                assign cell_clr_n[i] = clear & preset;
                assign cell_pre_n[i] = 1'b1;
            end

            jk_cell u_cell (
                .clk   (clk),
                .clr_n (cell_clr_n[i]),
                .pre_n (cell_pre_n[i]),
                .en    (en),
                .j     (next_j[i]),
                .k     (next_k[i]),
                .q     (q[i])
            );
        end
    endgenerate

    assign q_not = ~q;

    // Terminal count is suppressed while clear or preset is pending, since
    // the coming edge will not perform the wrap.
    assign tc = en & clear & preset &
                (((mode_sel == MODE_UP) & at_top) |
                 ((mode_sel == MODE_DN) & at_zero));

endmodule : jk_counter_reg

// File: tb/tb_jk_counter_reg.sv
// ---------------------------------------------------------------------------
// tb_jk_counter_reg
//   Directed test of jk_counter_reg with WIDTH=4, MODULUS=10 (so the default
//   preset value clamps to 9). Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_jk_counter_reg;

    localparam int WIDTH = 4;

    logic             clk;
    logic             clear;
    logic             preset;
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             sin;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_not;
    logic             tc;

    int checks   = 0;
    int failures = 0;

    jk_counter_reg #(
        .WIDTH   (WIDTH),
        .MODULUS (64'd10)
    ) dut (
        .clk    (clk),
        .clear  (clear),
        .preset (preset),
        .en     (en),
        .mode   (mode),
        .j      (j),
        .k      (k),
        .sin    (sin),
        .q      (q),
        .q_not  (q_not),
        .tc     (tc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle past it before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear  = 1'b0;
        preset = 1'b1;
        en     = 1'b0;
        mode   = 2'b00;
        j      = '0;
        k      = '0;
        sin    = 1'b0;

        // Reset state.
        step();
        check("reset_q", 32'(q), 32'h0);
        check("reset_q_not", 32'(q_not), 32'hF);
        check("reset_tc", 32'(tc), 32'h0);

        // Count up 0..9 then wrap; tc only while q=9.
        clear = 1'b1;
        en    = 1'b1;
        mode  = 2'b01;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("up_q_%0d", i), 32'(q), 32'(i));
            check($sformatf("up_tc_%0d", i), 32'(tc), (i == 9) ? 32'h1 : 32'h0);
            step();
        end
        check("up_wrap_q", 32'(q), 32'h0);

        // Count down from 0: 9, 8, 7; tc while q=0.
        mode = 2'b10;
        #1;
        check("dn_tc_at0", 32'(tc), 32'h1);
        step();
        check("dn_q_9", 32'(q), 32'h9);
        check("dn_tc_at9", 32'(tc), 32'h0);
        step();
        check("dn_q_8", 32'(q), 32'h8);
        step();
        check("dn_q_7", 32'(q), 32'h7);

        // JK mode: load 0011, then j=1010 k=0110 -> 1001, then toggle -> 0110.
        mode = 2'b00;
        j = 4'b0011;
        k = 4'b1100;
        #1;
        check("jk_tc_zero", 32'(tc), 32'h0);
        step();
        check("jk_load", 32'(q), 32'h3);
        j = 4'b1010;
        k = 4'b0110;
        step();
        check("jk_mixed", 32'(q), 32'h9);
        check("jk_mixed_qn", 32'(q_not), 32'h6);
        j = 4'b1111;
        k = 4'b1111;
        step();
        check("jk_toggle", 32'(q), 32'h6);

        // Shift left 1,0,1,1 from 0 -> 1011, hold with en=0, then MSB drop.
        clear = 1'b0;
        step();
        clear = 1'b1;
        check("shl_start", 32'(q), 32'h0);
        mode = 2'b11;
        sin = 1'b1; step(); check("shl_1", 32'(q), 32'h1);
        sin = 1'b0; step(); check("shl_2", 32'(q), 32'h2);
        sin = 1'b1; step(); check("shl_3", 32'(q), 32'h5);
        sin = 1'b1; step(); check("shl_4", 32'(q), 32'hB);
        check("shl_tc_zero", 32'(tc), 32'h0);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("hold_%0d", i), 32'(q), 32'hB);
        end
        en  = 1'b1;
        sin = 1'b0;
        step();
        check("shl_msb_drop", 32'(q), 32'h6);

        // Load 7, then clear and preset together -> 0; preset alone -> 9.
        mode = 2'b00;
        j = 4'b0111;
        k = 4'b1000;
        step();
        check("load_7", 32'(q), 32'h7);
        clear  = 1'b0;
        preset = 1'b0;
        step();
        check("clr_pre_both", 32'(q), 32'h0);
        clear = 1'b1;
        step();
        check("preset_val", 32'(q), 32'h9);

        // tc suppressed while clear is low; clear mid-count, then resume.
        preset = 1'b1;
        mode   = 2'b01;
        #1;
        check("tc_at9_up", 32'(tc), 32'h1);
        clear = 1'b0;
        #1;
        check("tc_clear_low", 32'(tc), 32'h0);
        step();
        check("clear_midcount", 32'(q), 32'h0);
        clear = 1'b1;
        step();
        check("resume_count", 32'(q), 32'h1);

        // Out-of-range 1111: up wraps to 0, down loads 9.
        mode = 2'b00;
        j = 4'b1111;
        k = 4'b0000;
        step();
        check("oor_load", 32'(q), 32'hF);
        mode = 2'b01;
        #1;
        check("oor_tc_up", 32'(tc), 32'h1);
        step();
        check("oor_up_wrap", 32'(q), 32'h0);
        mode = 2'b00;
        step();
        check("oor_reload", 32'(q), 32'hF);
        mode = 2'b10;
        #1;
        check("oor_tc_dn", 32'(tc), 32'h0);
        step();
        check("oor_dn_load", 32'(q), 32'h9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_jk_counter_reg

// File: doc/jk_counter_reg.md
# jk_counter_reg

Parametrised WIDTH-bit register built from JK cells, with per-bit JK control plus modulo up/down counting and shift modes. Synchronous active-low clear and preset replace the single-bit flip-flop's undefined both-asserted case with a fixed priority. The block is the general-purpose state element for counter, shift and lab-exercise datapaths in the digital-circuits designs.

## Interface
- WIDTH, 8: register width in bits (1..32).
- MODULUS, 2**WIDTH: count modulus for up/down modes (2..2**WIDTH).
- PRESET_VALUE, {WIDTH{1'b1}} truncated to MODULUS-1 if larger: value loaded by preset.

- clk  input  1  rising-edge clock; single clock domain.
- clear  input  1  synchronous active-low reset; q <= 0.
- preset  input  1  synchronous active-low preset; q <= PRESET_VALUE.
- en  input  1  operation enable; 0 = hold, except clear and preset.
- mode  input  2  00 JK, 01 count up, 10 count down, 11 shift left.
- j  input  WIDTH  per-bit J (mode 00).
- k  input  WIDTH  per-bit K (mode 00).
- sin  input  1  serial input to bit 0 (mode 11).
- q  output  WIDTH  register state.
- q_not  output  WIDTH  ~q, combinational.
- tc  output  1  terminal count, combinational.

## Operation
- Priority each rising edge: clear low > preset low > en low (hold) > mode.
- clear low: q <= 0 regardless of preset. Both low gives 0, never X.
- Mode 00: per bit, JK=00 hold, 01 clear bit, 10 set bit, 11 toggle bit.
- Mode 01: if q >= MODULUS-1 then q <= 0, else q <= q+1. Implemented by per-bit toggle (J=K=all-lower-bits-one) plus wrap override.
- Mode 10: if q == 0 or q > MODULUS-1 then q <= MODULUS-1, else q <= q-1.
- Mode 11: q <= {q[WIDTH-2:0], sin}; the MSB is discarded. For WIDTH=1, q <= sin.
- tc = en & ((mode==01 & q>=MODULUS-1) | (mode==10 & q==0)). It is 0 in modes 00 and 11 and while clear or preset is low.
- Out-of-range q can only arise via mode 00 or shift. It is legal and is corrected on the next count step per the rules above.

## Timing
- All state updates occur on the rising clk edge. Latency is 1 cycle from input to q.
- Reset values: q = 0, q_not = all ones, tc = 0.
- clear and preset are sampled only at clk edges. No asynchronous path exists.
- A mode change takes effect on the same edge it is sampled. No pipeline exists and no state is carried between modes beyond q.
- tc is valid in the cycle before the wrap edge, for cascading into the next stage's en.
- Clear asserted mid-count: q is 0 on the next edge. Counting resumes from 0 on the first edge with clear high and en high.

## Structure
- Package jk_reg_pkg holds the mode encodings MODE_JK=2'b00, MODE_UP=2'b01, MODE_DN=2'b10, MODE_SHL=2'b11.
- Sub-module jk_cell: a one-bit JK flip-flop with clr_n, pre_n and en, plus j and k inputs. It implements the same priority rules.
- Top level: a generate loop of WIDTH jk_cell instances, with a combinational next-J/K decoder per mode. Wrap and out-of-range overrides map to direct set/clear J/K pairs.

## Test plan
- WIDTH=4, MODULUS=10, mode 01, en=1 from clear: q steps 0..9 then 0. tc=1 only while q=9.
- Mode 10 from q=0: the next value is 9. The count continues 8, 7, and tc=1 while q=0.
- Mode 00 with j=4'b1010, k=4'b0110 from q=4'b0011: q=4'b1001. Then j=k=4'b1111: q=4'b0110.
- Mode 11 with sin sequence 1,0,1,1 from q=0: q ends 4'b1011. Then en=0 for 3 cycles: q holds.
- clear=0 and preset=0 together at q=7: q=0 on the next edge. Then preset=0 alone: q=PRESET_VALUE (9 when MODULUS=10).
- Mode 00 sets q=4'b1111 (above MODULUS-1), then mode 01: the next q is 0. Mode 10 from 4'b1111: the next q is 9.
